// File: rtl/hdpldadapt_cmn_async_unload_ctrl.sv
// Periodic / on-demand unload sequencer for an async capture bus: pulses unload,
// waits for the bus to settle, then latches the captured value and tracks per-bit changes.
module hdpldadapt_cmn_async_unload_ctrl #(
  parameter int DWIDTH        = 2,
  parameter int CNT_WIDTH     = 8,
  parameter int UNLOAD_CYCLES = 2,
  parameter int WAIT_CYCLES   = 6,
  parameter int RESET_VAL     = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DWIDTH-1:0]    capt_data,
  input  logic                 r_unload_en,
  input  logic [CNT_WIDTH-1:0] r_interval,
  input  logic                 upd_req,
  input  logic [DWIDTH-1:0]    clr_sticky,
  output logic                 unload,
  output logic [DWIDTH-1:0]    status_out,
  output logic [DWIDTH-1:0]    change_sticky,
  output logic                 status_valid,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE, UNLOAD, SETTLE, LATCH} state_t;

  localparam logic [3:0]        ULAST      = 4'(UNLOAD_CYCLES - 1);
  localparam logic [3:0]        WLAST      = 4'(WAIT_CYCLES - 1);
  localparam logic [DWIDTH-1:0] STATUS_RST = (RESET_VAL != 0) ? '1 : '0;

  state_t                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [3:0]             phase_q, phase_d;
  logic                   pending_q, pending_d;
  logic                   first_done_q, first_done_d;
  logic                   unload_q, unload_d;
  logic                   busy_q, busy_d;
  logic                   valid_q, valid_d;
  logic [DWIDTH-1:0]      status_q, status_d;
  logic [DWIDTH-1:0]      sticky_q, sticky_d;
  logic [DWIDTH-1:0]      change_set;
  logic                   start_seq;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      phase_q      <= '0;
      pending_q    <= 1'b0;
      first_done_q <= 1'b0;
      unload_q     <= 1'b0;
      busy_q       <= 1'b0;
      valid_q      <= 1'b0;
      status_q     <= STATUS_RST;
      sticky_q     <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      phase_q      <= phase_d;
      pending_q    <= pending_d;
      first_done_q <= first_done_d;
      unload_q     <= unload_d;
      busy_q       <= busy_d;
      valid_q      <= valid_d;
      status_q     <= status_d;
      sticky_q     <= sticky_d;
    end
  end

  // A request arriving while busy is remembered once and consumed when UNLOAD is next entered.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    phase_d   = phase_q;
    pending_d = pending_q;
    start_seq = (r_unload_en && (cnt_q == r_interval)) || upd_req || pending_q;
    if (state_q != IDLE && upd_req) pending_d = 1'b1;
    case (state_q)
      IDLE: begin
        cnt_d = r_unload_en ? cnt_q + 1'b1 : '0;
        if (start_seq) begin
          state_d   = UNLOAD;
          phase_d   = '0;
          pending_d = 1'b0;
        end
      end
      UNLOAD: begin
        if (phase_q == ULAST) begin
          state_d = SETTLE;
          phase_d = '0;
        end else begin
          phase_d = phase_q + 4'd1;
        end
      end
      SETTLE: begin
        if (phase_q == WLAST) begin
          state_d = LATCH;
          phase_d = '0;
        end else begin
          phase_d = phase_q + 4'd1;
        end
      end
      LATCH: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are computed from the next state so the registered copies line up with state_q.
  always_comb begin
    unload_d     = (state_d == UNLOAD);
    busy_d       = (state_d != IDLE);
    valid_d      = (state_q == LATCH);
    status_d     = (state_q == LATCH) ? capt_data : status_q;
    first_done_d = first_done_q | (state_q == LATCH);
    change_set   = (state_q == LATCH && first_done_q) ? (capt_data ^ status_q) : '0;
    sticky_d     = (sticky_q & ~clr_sticky) | change_set;
  end

  assign unload        = unload_q;
  assign busy          = busy_q;
  assign status_valid  = valid_q;
  assign status_out    = status_q;
  assign change_sticky = sticky_q;

endmodule

// File: tb/tb_hdpldadapt_cmn_async_unload_ctrl.sv
// Bench for hdpldadapt_cmn_async_unload_ctrl: directed vector table, corner-case
// sequences, then random stimulus against a sequence-age reference model.
module tb_hdpldadapt_cmn_async_unload_ctrl;

  localparam int U  = 2;
  localparam int W  = 6;
  localparam int CW = 8;

  logic          clk;
  logic          rst_n;
  logic [1:0]    capt_data;
  logic          r_unload_en;
  logic [CW-1:0] r_interval;
  logic          upd_req;
  logic [1:0]    clr_sticky;
  logic          unload;
  logic [1:0]    status_out;
  logic [1:0]    change_sticky;
  logic          status_valid;
  logic          busy;

  int nChecks = 0;
  int nFails  = 0;

  hdpldadapt_cmn_async_unload_ctrl #(
    .DWIDTH(2), .CNT_WIDTH(CW), .UNLOAD_CYCLES(U), .WAIT_CYCLES(W), .RESET_VAL(1)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .capt_data    (capt_data),
    .r_unload_en  (r_unload_en),
    .r_interval   (r_interval),
    .upd_req      (upd_req),
    .clr_sticky   (clr_sticky),
    .unload       (unload),
    .status_out   (status_out),
    .change_sticky(change_sticky),
    .status_valid (status_valid),
    .busy         (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       en;
    logic [7:0] interval;
    logic       upd;
    logic [1:0] clr;
    logic [1:0] capt;
    int         n;
    logic       eUnload;
    logic       eBusy;
    logic       eValid;
    logic [1:0] eStatus;
    logic [1:0] eSticky;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic en, input logic [7:0] iv, input logic upd,
                              input logic [1:0] clr, input logic [1:0] capt, input int n,
                              input logic eu, input logic eb, input logic ev,
                              input logic [1:0] es, input logic [1:0] ek);
    vec_t v;
    v.en = en; v.interval = iv; v.upd = upd; v.clr = clr; v.capt = capt; v.n = n;
    v.eUnload = eu; v.eBusy = eb; v.eValid = ev; v.eStatus = es; v.eSticky = ek;
    return v;
  endfunction

  // Reference model: a sequence is an age counter since UNLOAD entry (-1 when idle).
  int         age;
  int         idleCnt;
  bit         pend;
  bit         fd;
  logic [1:0] mStat;
  logic [1:0] mSticky;
  bit         mValid;

  task automatic modelReset();
    age = -1; idleCnt = 0; pend = 0; fd = 0;
    mStat = 2'b11; mSticky = 2'b00; mValid = 0;
  endtask

  task automatic modelStep();
    logic [1:0] setBits;
    bit go;
    setBits = 2'b00;
    mValid  = 0;
    if (age < 0) begin
      go = (r_unload_en && idleCnt == int'(r_interval)) || upd_req || pend;
      idleCnt = r_unload_en ? (idleCnt + 1) % (1 << CW) : 0;
      if (go) begin
        age  = 0;
        pend = 0;
      end
    end else begin
      if (upd_req) pend = 1;
      if (age == U + W) begin
        if (fd) setBits = capt_data ^ mStat;
        fd = 1; mStat = capt_data; mValid = 1; age = -1; idleCnt = 0;
      end else begin
        age++;
      end
    end
    mSticky = (mSticky & ~clr_sticky) | setBits;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkAll(input string tag, input logic eu, input logic eb, input logic ev,
                          input logic [1:0] es, input logic [1:0] ek);
    checkOutput({tag, ".unload"}, 8'(unload), 8'(eu));
    checkOutput({tag, ".busy"}, 8'(busy), 8'(eb));
    checkOutput({tag, ".status_valid"}, 8'(status_valid), 8'(ev));
    checkOutput({tag, ".status_out"}, 8'(status_out), 8'(es));
    checkOutput({tag, ".change_sticky"}, 8'(change_sticky), 8'(ek));
  endtask

  task automatic applyStimulus(input vec_t v);
    r_unload_en = v.en;
    r_interval  = v.interval;
    upd_req     = v.upd;
    clr_sticky  = v.clr;
    capt_data   = v.capt;
    repeat (v.n) tick();
  endtask

  initial begin
    rst_n = 1'b0; r_unload_en = 1'b0; r_interval = 8'd3; upd_req = 1'b0;
    clr_sticky = 2'b00; capt_data = 2'b10;

    //        en int   upd clr    capt   n   unl bsy val stat   stk
    vecs.push_back(mk(0, 8'd3, 0, 2'b00, 2'b10, 1, 0, 0, 0, 2'b11, 2'b00));
    vecs.push_back(mk(0, 8'd3, 1, 2'b00, 2'b10, 1, 1, 1, 0, 2'b11, 2'b00));
    vecs.push_back(mk(0, 8'd3, 0, 2'b00, 2'b10, 2, 0, 1, 0, 2'b11, 2'b00));
    vecs.push_back(mk(0, 8'd3, 0, 2'b00, 2'b10, 6, 0, 1, 0, 2'b11, 2'b00));
    vecs.push_back(mk(0, 8'd3, 0, 2'b00, 2'b10, 1, 0, 0, 1, 2'b10, 2'b00));
    vecs.push_back(mk(0, 8'd3, 0, 2'b00, 2'b10, 1, 0, 0, 0, 2'b10, 2'b00));
    vecs.push_back(mk(0, 8'd3, 0, 2'b00, 2'b10, 20, 0, 0, 0, 2'b10, 2'b00));
    vecs.push_back(mk(1, 8'd3, 0, 2'b00, 2'b01, 3, 0, 0, 0, 2'b10, 2'b00));
    vecs.push_back(mk(1, 8'd3, 0, 2'b00, 2'b01, 1, 1, 1, 0, 2'b10, 2'b00));
    vecs.push_back(mk(1, 8'd3, 0, 2'b00, 2'b01, 9, 0, 0, 1, 2'b01, 2'b11));
    vecs.push_back(mk(1, 8'd3, 0, 2'b01, 2'b01, 1, 0, 0, 0, 2'b01, 2'b10));
    vecs.push_back(mk(1, 8'd3, 0, 2'b00, 2'b01, 2, 0, 0, 0, 2'b01, 2'b10));
    vecs.push_back(mk(1, 8'd3, 0, 2'b00, 2'b01, 1, 1, 1, 0, 2'b01, 2'b10));
    vecs.push_back(mk(0, 8'd3, 0, 2'b00, 2'b01, 9, 0, 0, 1, 2'b01, 2'b10));
    vecs.push_back(mk(0, 8'd3, 0, 2'b00, 2'b01, 10, 0, 0, 0, 2'b01, 2'b10));
    vecs.push_back(mk(0, 8'd3, 1, 2'b00, 2'b01, 1, 1, 1, 0, 2'b01, 2'b10));
    vecs.push_back(mk(0, 8'd3, 0, 2'b00, 2'b01, 3, 0, 1, 0, 2'b01, 2'b10));
    vecs.push_back(mk(0, 8'd3, 1, 2'b00, 2'b01, 1, 0, 1, 0, 2'b01, 2'b10));
    vecs.push_back(mk(0, 8'd3, 0, 2'b00, 2'b01, 1, 0, 1, 0, 2'b01, 2'b10));
    vecs.push_back(mk(0, 8'd3, 1, 2'b00, 2'b01, 1, 0, 1, 0, 2'b01, 2'b10));
    vecs.push_back(mk(0, 8'd3, 0, 2'b00, 2'b01, 3, 0, 0, 1, 2'b01, 2'b10));
    vecs.push_back(mk(0, 8'd3, 0, 2'b00, 2'b01, 1, 1, 1, 0, 2'b01, 2'b10));
    vecs.push_back(mk(0, 8'd3, 0, 2'b00, 2'b01, 9, 0, 0, 1, 2'b01, 2'b10));
    vecs.push_back(mk(0, 8'd3, 0, 2'b00, 2'b01, 1, 0, 0, 0, 2'b01, 2'b10));
    vecs.push_back(mk(0, 8'd3, 0, 2'b00, 2'b01, 5, 0, 0, 0, 2'b01, 2'b10));
    vecs.push_back(mk(1, 8'd0, 0, 2'b00, 2'b01, 1, 1, 1, 0, 2'b01, 2'b10));
    vecs.push_back(mk(1, 8'd0, 0, 2'b00, 2'b01, 9, 0, 0, 1, 2'b01, 2'b10));
    vecs.push_back(mk(1, 8'd0, 0, 2'b00, 2'b01, 1, 1, 1, 0, 2'b01, 2'b10));
    vecs.push_back(mk(0, 8'd0, 0, 2'b00, 2'b01, 9, 0, 0, 1, 2'b01, 2'b10));
    vecs.push_back(mk(0, 8'd0, 0, 2'b00, 2'b01, 3, 0, 0, 0, 2'b01, 2'b10));
    vecs.push_back(mk(1, 8'd2, 0, 2'b00, 2'b01, 2, 0, 0, 0, 2'b01, 2'b10));
    vecs.push_back(mk(1, 8'd2, 1, 2'b00, 2'b01, 1, 1, 1, 0, 2'b01, 2'b10));
    vecs.push_back(mk(0, 8'd2, 0, 2'b00, 2'b01, 9, 0, 0, 1, 2'b01, 2'b10));
    vecs.push_back(mk(0, 8'd2, 0, 2'b00, 2'b01, 1, 0, 0, 0, 2'b01, 2'b10));
    vecs.push_back(mk(0, 8'd2, 0, 2'b00, 2'b01, 3, 0, 0, 0, 2'b01, 2'b10));

    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkAll($sformatf("vec%0d", i), vecs[i].eUnload, vecs[i].eBusy, vecs[i].eValid,
               vecs[i].eStatus, vecs[i].eSticky);
    end

    // Clear held across a LATCH that flips bit0: the new change wins on that bit.
    r_unload_en = 1'b0; upd_req = 1'b1; capt_data = 2'b00; clr_sticky = 2'b11;
    tick();
    upd_req = 1'b0;
    repeat (9) tick();
    checkAll("clrSetRace", 0, 0, 1, 2'b00, 2'b01);
    clr_sticky = 2'b00;
    tick();

    // Reset during UNLOAD aborts at once and never produces a valid pulse.
    upd_req = 1'b1;
    tick();
    upd_req = 1'b0;
    checkAll("preReset", 1, 1, 0, 2'b00, 2'b01);
    #2 rst_n = 1'b0;
    #1 checkAll("asyncReset", 0, 0, 0, 2'b11, 2'b00);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      checkOutput($sformatf("postReset%0d.status_valid", i), 8'(status_valid), 8'd0);
    end

    // Random phase against the reference model.
    rst_n = 1'b0;
    r_unload_en = 1'b1; r_interval = 8'd4; upd_req = 1'b0; clr_sticky = 2'b00;
    tick();
    modelReset();
    rst_n = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 49) == 0) r_unload_en = ~r_unload_en;
      if ($urandom_range(0, 39) == 0) r_interval = 8'($urandom_range(0, 6));
      upd_req    = ($urandom_range(0, 15) == 0);
      clr_sticky = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00;
      capt_data  = 2'($urandom);
      tick();
      modelStep();
      checkAll($sformatf("rand%0d", c), (age >= 0 && age < U), (age >= 0), mValid,
               mStat, mSticky);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
